dffnq_bank_arb: RTL and testbench

//  Two-requester controller for a negedge-capture register bank built from dffnq cells.
//  - Arbitrates single-word read/write commands from two ports.
//  - Sequences each command: launches address, data and write-enable on CLK rise; the bank

---
 rtl/dffnq_arb_pkg.sv | 40 ++++
 rtl/dffnq_rr_arb2.sv | 45 ++++
 rtl/dffnq_bank_arb.sv | 186 ++++++++++++++++++
 tb/tb_dffnq_bank_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dffnq_arb_pkg.sv
// -----------------------------------------------------------------------------
// dffnq_arb_pkg
// Shared types and constants for the dffnq register-bank arbiter.
//   - state_t : controller sequencing states (IDLE, ISSUE, DONE), 2-bit encoding
//   - cmd_t   : one latched bank command {we, addr, wd}
//   - PORT0/PORT1 : requester index values used for SEL and LAST
//   - make_cmd : packs the per-port request fields into a cmd_t
// No ports (package).
// -----------------------------------------------------------------------------
package dffnq_arb_pkg;

  localparam int ARB_DW = 8;
  localparam int ARB_AW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wd;
  } cmd_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  function automatic cmd_t make_cmd(input logic              we,
                                    input logic [ARB_AW-1:0] addr,
                                    input logic [ARB_DW-1:0] wd);
    cmd_t c;
    c.we   = we;
    c.addr = addr;
    c.wd   = wd;
    return c;
  endfunction

endpackage

// File: rtl/dffnq_rr_arb2.sv
// -----------------------------------------------------------------------------
// dffnq_rr_arb2
// Combinational two-way picker for the bank controller.
// Build option: DFFNQ_ARB_FIXED_PRIO_EN
//   defined   : port 0 always wins a tie, last is ignored
//   undefined : a tie goes to the port that was not served last (round-robin)
// Ports:
//   req   in  2  request vector {REQ1, REQ0}
//   last  in  1  index of the port served most recently
//   valid out 1  at least one request present
//   sel   out 1  winning port index (meaningful only when valid=1)
// -----------------------------------------------------------------------------
module dffnq_rr_arb2
  import dffnq_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       sel
);

  // Pick the winner among the presented requests
  always_comb begin
    valid = |req;
    sel   = PORT0;
`ifdef DFFNQ_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      sel = PORT0;
    end else if (req[1]) begin
      sel = PORT1;
    end else begin
      sel = PORT0;
    end
`else
    case (req)
      2'b01:   sel = PORT0;
      2'b10:   sel = PORT1;
      // Tie: hand the bank to whichever port did not get it last time
      2'b11:   sel = (last == PORT0) ? PORT1 : PORT0;
      default: sel = PORT0;
    endcase
`endif
  end

endmodule

// File: rtl/dffnq_bank_arb.sv
// -----------------------------------------------------------------------------
// dffnq_bank_arb
// Two-requester controller for a negedge-capture register bank built from
// dffnq cells. Each command is launched on a CLK rise (ISSUE), captured by the
// bank on the following fall, and completed with a one-cycle grant (DONE).
// Build option: DFFNQ_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins
// ties) instead of the default round-robin.
// Ports:
//   CLK        in   1   clock, all state changes on rising edge
//   RN         in   1   synchronous active-low reset
//   REQ0/REQ1  in   1   per-port request, held with its command until GNTx
//   WE0/WE1    in   1   1 = write, 0 = read
//   ADDR0/1    in   AW  word address
//   WD0/WD1    in   DW  write data
//   GNT0/GNT1  out  1   one-cycle completion pulse to the served port
//   RD         out  DW  read data, valid with RVALID, held until next read
//   RVALID     out  1   one-cycle pulse with GNTx of a read
//   BUSY       out  1   high whenever the controller is not IDLE
//   BANK_WE    out  1   bank write strobe (bank samples on CLK fall)
//   BANK_ADDR  out  AW  bank word select, held outside ISSUE
//   BANK_WD    out  DW  bank write data, held outside ISSUE
//   BANK_RD    in   DW  bank read data, settles after CLK fall
// -----------------------------------------------------------------------------
module dffnq_bank_arb
  import dffnq_arb_pkg::*;
#(
  parameter int DW = ARB_DW,
  parameter int AW = ARB_AW
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WD0,
  input  logic [DW-1:0] WD1,
  output logic          GNT0,
  output logic          GNT1,
  output logic [DW-1:0] RD,
  output logic          RVALID,
  output logic          BUSY,
  output logic          BANK_WE,
  output logic [AW-1:0] BANK_ADDR,
  output logic [DW-1:0] BANK_WD,
  input  logic [DW-1:0] BANK_RD
);

  state_t        state_r,     state_nxt_s;
  cmd_t          cmd_r,       cmd_nxt_s;
  cmd_t          pick_cmd_s;
  logic          sel_r,       sel_nxt_s;
  logic          last_r,      last_nxt_s;
  logic          pick_valid_s;
  logic          pick_sel_s;
  logic          gnt0_r,      gnt0_nxt_s;
  logic          gnt1_r,      gnt1_nxt_s;
  logic          rvalid_r,    rvalid_nxt_s;
  logic          busy_r,      busy_nxt_s;
  logic          bank_we_r,   bank_we_nxt_s;
  logic [AW-1:0] bank_addr_r, bank_addr_nxt_s;
  logic [DW-1:0] bank_wd_r,   bank_wd_nxt_s;
  logic [DW-1:0] rd_r,        rd_nxt_s;

  dffnq_rr_arb2 u_arb (
    .req   ({REQ1, REQ0}),
    .last  (last_r),
    .valid (pick_valid_s),
    .sel   (pick_sel_s)
  );

  // Gather the winning port's command fields
  always_comb begin
    if (pick_sel_s == PORT1) begin
      pick_cmd_s = make_cmd(WE1, ADDR1, WD1);
    end else begin
      pick_cmd_s = make_cmd(WE0, ADDR0, WD0);
    end
  end

  // Next-state and next-output decode for the IDLE/ISSUE/DONE sequence
  always_comb begin
    state_nxt_s     = state_r;
    cmd_nxt_s       = cmd_r;
    sel_nxt_s       = sel_r;
    last_nxt_s      = last_r;
    gnt0_nxt_s      = 1'b0;
    gnt1_nxt_s      = 1'b0;
    rvalid_nxt_s    = 1'b0;
    bank_we_nxt_s   = 1'b0;
    bank_addr_nxt_s = bank_addr_r;
    bank_wd_nxt_s   = bank_wd_r;
    rd_nxt_s        = rd_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s     = ISSUE;
          cmd_nxt_s       = pick_cmd_s;
          sel_nxt_s       = pick_sel_s;
          // Bank pins are loaded on entry so they are stable for the
          // whole ISSUE cycle, including its falling edge.
          bank_we_nxt_s   = pick_cmd_s.we;
          bank_addr_nxt_s = pick_cmd_s.addr;
          bank_wd_nxt_s   = pick_cmd_s.wd;
        end else begin
          state_nxt_s     = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s     = DONE;
        bank_addr_nxt_s = cmd_r.addr;
        bank_wd_nxt_s   = cmd_r.wd;
        // BANK_RD has settled since the fall inside ISSUE
        if (!cmd_r.we) begin
          rd_nxt_s = BANK_RD;
        end else begin
          rd_nxt_s = rd_r;
        end
        if (sel_r == PORT1) begin
          gnt1_nxt_s = 1'b1;
        end else begin
          gnt0_nxt_s = 1'b1;
        end
        rvalid_nxt_s = ~cmd_r.we;
      end
      DONE: begin
        state_nxt_s = IDLE;
        last_nxt_s  = sel_r;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command, arbitration history and registered outputs
  always_ff @(posedge CLK) begin
    if (!RN) begin
      cmd_r       <= '0;
      sel_r       <= PORT0;
      last_r      <= PORT1;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      rvalid_r    <= 1'b0;
      busy_r      <= 1'b0;
      bank_we_r   <= 1'b0;
      bank_addr_r <= '0;
      bank_wd_r   <= '0;
      rd_r        <= '0;
    end else begin
      cmd_r       <= cmd_nxt_s;
      sel_r       <= sel_nxt_s;
      last_r      <= last_nxt_s;
      gnt0_r      <= gnt0_nxt_s;
      gnt1_r      <= gnt1_nxt_s;
      rvalid_r    <= rvalid_nxt_s;
      busy_r      <= busy_nxt_s;
      bank_we_r   <= bank_we_nxt_s;
      bank_addr_r <= bank_addr_nxt_s;
      bank_wd_r   <= bank_wd_nxt_s;
      rd_r        <= rd_nxt_s;
    end
  end

  assign GNT0      = gnt0_r;
  assign GNT1      = gnt1_r;
  assign RVALID    = rvalid_r;
  assign BUSY      = busy_r;
  assign BANK_WE   = bank_we_r;
  assign BANK_ADDR = bank_addr_r;
  assign BANK_WD   = bank_wd_r;
  assign RD        = rd_r;

endmodule

// File: tb/tb_dffnq_bank_arb.sv
// -----------------------------------------------------------------------------
// tb_dffnq_bank_arb
// Directed scenarios plus a randomized two-port traffic run for dffnq_bank_arb.
// A negedge-capture bank model sits on the bank pins; expected values come from
// fixed constants and a transaction-level reference (one command accepted per
// three edges, grant one edge after acceptance, round-robin or fixed priority).
// -----------------------------------------------------------------------------
module tb_dffnq_bank_arb;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          CLK;
  logic          RN;
  logic          REQ0, REQ1, WE0, WE1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] WD0, WD1;
  logic          GNT0, GNT1, RVALID, BUSY, BANK_WE;
  logic [DW-1:0] RD, BANK_WD, BANK_RD;
  logic [AW-1:0] BANK_ADDR;

  logic [DW-1:0] bank_mem [8];
  logic [DW-1:0] ref_mem  [8];

  int n_cmp = 0;
  int n_bad = 0;

  dffnq_bank_arb #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RN(RN),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WD0(WD0), .WD1(WD1),
    .GNT0(GNT0), .GNT1(GNT1), .RD(RD), .RVALID(RVALID), .BUSY(BUSY),
    .BANK_WE(BANK_WE), .BANK_ADDR(BANK_ADDR), .BANK_WD(BANK_WD),
    .BANK_RD(BANK_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bank model: captures on the falling edge, reads combinationally
  always @(negedge CLK) begin
    if (BANK_WE) bank_mem[BANK_ADDR] <= BANK_WD;
  end
  assign BANK_RD = bank_mem[BANK_ADDR];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_port(input bit port, input bit req, input bit we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (port) begin
      REQ1 = req; WE1 = we; ADDR1 = addr; WD1 = wd;
    end else begin
      REQ0 = req; WE0 = we; ADDR0 = addr; WD0 = wd;
    end
  endtask

  task automatic apply_reset();
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    RN   = 1'b0;
    tick();
    tick();
    RN   = 1'b1;
  endtask

  // Reference arbitration rule
  function automatic bit tb_pick(input bit r0, input bit r1, input bit last);
    if (r0 && !r1) return 1'b0;
    if (r1 && !r0) return 1'b1;
`ifdef DFFNQ_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return !last;
`endif
  endfunction

  // Runs one command on an idle DUT and reports what was observed
  task automatic run_single(input bit port, input bit we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            output int lat, output int we_cyc,
                            output logic [DW-1:0] rd_g, output bit rv_g,
                            output bit other_g);
    lat = -1; we_cyc = 0; rd_g = '0; rv_g = 1'b0; other_g = 1'b0;
    set_port(port, 1'b1, we, addr, wd);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (BANK_WE) we_cyc++;
      if ((port ? GNT0 : GNT1) === 1'b1) other_g = 1'b1;
      if ((port ? GNT1 : GNT0) === 1'b1) begin
        lat  = i;
        rd_g = RD;
        rv_g = RVALID;
        break;
      end
    end
    set_port(port, 1'b0, 1'b0, '0, '0);
    tick();
    if (BANK_WE) we_cyc++;
  endtask

  task automatic test_reset();
    logic [23:0] got;
    set_port(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    set_port(1'b0, 1'b1, 1'b1, 3'd1, 8'h5A);
    RN = 1'b0;
    tick();
    tick();
    got = {GNT0, GNT1, RVALID, BUSY, BANK_WE, BANK_ADDR, BANK_WD, RD};
    n_cmp++;
    if (got !== 24'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected %h", got, 24'h0);
    end
    RN = 1'b1;
    tick();
    n_cmp++;
    if ({BUSY, BANK_WE, BANK_ADDR, BANK_WD, GNT0} !== {1'b1, 1'b1, 3'd1, 8'h5A, 1'b0}) begin
      n_bad++; $display("FAIL reset_issue: got %b%b %h %h %b expected 11 1 5a 0",
                        BUSY, BANK_WE, BANK_ADDR, BANK_WD, GNT0);
    end
    tick();
    n_cmp++;
    if ({GNT0, GNT1, RVALID} !== 3'b100) begin
      n_bad++; $display("FAIL reset_first_gnt: got %b expected 100", {GNT0, GNT1, RVALID});
    end
    REQ0 = 1'b0;
    tick();
    n_cmp++;
    if ({GNT0, BUSY, BANK_WE} !== 3'b000) begin
      n_bad++; $display("FAIL reset_back_idle: got %b expected 000", {GNT0, BUSY, BANK_WE});
    end
  endtask

  task automatic test_write_read();
    int lat, wec; logic [DW-1:0] rdg; bit rv, oth;
    run_single(1'b0, 1'b1, 3'd3, 8'hA5, lat, wec, rdg, rv, oth);
    n_cmp++;
    if (lat !== 2 || oth !== 1'b0 || rv !== 1'b0) begin
      n_bad++; $display("FAIL wr_grant: got lat=%0d other=%0d rv=%0d expected 2 0 0", lat, oth, rv);
    end
    n_cmp++;
    if (wec !== 1) begin
      n_bad++; $display("FAIL wr_we_width: got %0d expected 1", wec);
    end
    run_single(1'b0, 1'b0, 3'd3, 8'h00, lat, wec, rdg, rv, oth);
    n_cmp++;
    if (lat !== 2 || rv !== 1'b1) begin
      n_bad++; $display("FAIL rd_grant: got lat=%0d rvalid=%0d expected 2 1", lat, rv);
    end
    n_cmp++;
    if (rdg !== 8'hA5) begin
      n_bad++; $display("FAIL rd_data: got %h expected a5", rdg);
    end
    n_cmp++;
    if (wec !== 0) begin
      n_bad++; $display("FAIL rd_no_we: got %0d expected 0", wec);
    end
    n_cmp++;
    if (RD !== 8'hA5 || RVALID !== 1'b0) begin
      n_bad++; $display("FAIL rd_hold: got %h/%b expected a5/0", RD, RVALID);
    end
  endtask

  task automatic test_tie();
    int gt[$]; bit gp[$]; int et[$]; bit ep[$]; bit last;
    apply_reset();
    set_port(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
    set_port(1'b1, 1'b1, 1'b0, 3'd1, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (GNT0) begin gt.push_back(i); gp.push_back(1'b0); end
      if (GNT1) begin gt.push_back(i); gp.push_back(1'b1); end
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    tick();
    last = 1'b1;
    for (int t = 1; t <= 10; t += 3) begin
      bit w;
      w = tb_pick(1'b1, 1'b1, last);
      et.push_back(t + 1);
      ep.push_back(w);
      last = w;
    end
    n_cmp++;
    if (gt.size() !== et.size()) begin
      n_bad++; $display("FAIL tie_count: got %0d expected %0d", gt.size(), et.size());
    end else begin
      for (int k = 0; k < et.size(); k++) begin
        n_cmp++;
        if (gt[k] !== et[k] || gp[k] !== ep[k]) begin
          n_bad++; $display("FAIL tie_grant%0d: got port%0d@%0d expected port%0d@%0d",
                            k, gp[k], gt[k], ep[k], et[k]);
        end
      end
    end
  endtask

  task automatic test_simul_writes();
    int gt[$]; bit gp[$]; int lat, wec; logic [DW-1:0] rdg; bit rv, oth;
    apply_reset();
    set_port(1'b0, 1'b1, 1'b1, 3'd5, 8'h11);
    set_port(1'b1, 1'b1, 1'b1, 3'd5, 8'h22);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (GNT0) begin gt.push_back(i); gp.push_back(1'b0); REQ0 = 1'b0; end
      if (GNT1) begin gt.push_back(i); gp.push_back(1'b1); REQ1 = 1'b0; end
    end
    n_cmp++;
    if (gt.size() !== 2) begin
      n_bad++; $display("FAIL sim_wr_count: got %0d expected 2", gt.size());
    end else begin
      n_cmp++;
      if (gp[0] !== 1'b0 || gt[0] !== 2) begin
        n_bad++; $display("FAIL sim_wr_first: got port%0d@%0d expected port0@2", gp[0], gt[0]);
      end
      n_cmp++;
      if (gp[1] !== 1'b1 || gt[1] !== 5) begin
        n_bad++; $display("FAIL sim_wr_second: got port%0d@%0d expected port1@5", gp[1], gt[1]);
      end
    end
    run_single(1'b0, 1'b0, 3'd5, 8'h00, lat, wec, rdg, rv, oth);
    n_cmp++;
    if (rdg !== 8'h22 || rv !== 1'b1) begin
      n_bad++; $display("FAIL sim_wr_readback: got %h/%b expected 22/1", rdg, rv);
    end
  endtask

  task automatic test_reset_midop();
    int first_i; bit first_p; bit saw0;
    first_i = -1; first_p = 1'b0; saw0 = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    set_port(1'b1, 1'b1, 1'b1, 3'd6, 8'h77);
    tick();
    n_cmp++;
    if ({BUSY, BANK_WE, BANK_ADDR} !== {1'b1, 1'b1, 3'd6}) begin
      n_bad++; $display("FAIL midop_issue: got %b%b %h expected 11 6", BUSY, BANK_WE, BANK_ADDR);
    end
    RN = 1'b0;
    tick();
    n_cmp++;
    if ({GNT0, GNT1, RVALID, BANK_WE, BUSY} !== 5'b00000) begin
      n_bad++; $display("FAIL midop_abort: got %b expected 00000", {GNT0, GNT1, RVALID, BANK_WE, BUSY});
    end
    RN = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (GNT0) saw0 = 1'b1;
      if ((GNT0 || GNT1) && first_i < 0) begin first_i = i; first_p = GNT1; end
      if (GNT1) REQ1 = 1'b0;
    end
    n_cmp++;
    if (first_i !== 2 || first_p !== 1'b1 || saw0 !== 1'b0) begin
      n_bad++; $display("FAIL midop_pending: got port%0d@%0d gnt0seen=%0d expected port1@2 0",
                        first_p, first_i, saw0);
    end
  endtask

  task automatic test_drop_req();
    int lat, wec; logic [DW-1:0] rdg; bit rv, oth;
    run_single(1'b0, 1'b1, 3'd0, 8'h3C, lat, wec, rdg, rv, oth);
    set_port(1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    tick();
    REQ1 = 1'b0;
    tick();
    n_cmp++;
    if ({GNT1, GNT0, RVALID, RD} !== {1'b1, 1'b0, 1'b1, 8'h3C}) begin
      n_bad++; $display("FAIL drop_gnt: got %b%b%b %h expected 101 3c", GNT1, GNT0, RVALID, RD);
    end
    tick();
    n_cmp++;
    if ({GNT1, RVALID, BUSY} !== 3'b000) begin
      n_bad++; $display("FAIL drop_end: got %b expected 000", {GNT1, RVALID, BUSY});
    end
    tick();
    tick();
    n_cmp++;
    if ({BUSY, BANK_WE, GNT0, GNT1} !== 4'b0000) begin
      n_bad++; $display("FAIL drop_no_second: got %b expected 0000", {BUSY, BANK_WE, GNT0, GNT1});
    end
  endtask

  task automatic test_random();
    int lat, wec; logic [DW-1:0] rdg; bit rv, oth;
    bit act0, act1, m_last, sched_port, sched_we, r0, r1, w0, w1, p;
    int edge_n, next_sample, sched_edge;
    logic [AW-1:0] a0, a1, m_addr;
    logic [DW-1:0] d0, d1, m_wd, m_rd, pend_rd, dv;
    logic [23:0] got, exp;
    for (int a = 0; a < 8; a++) begin
      dv = 8'($urandom_range(0, 255));
      ref_mem[a] = dv;
      run_single(1'b0, 1'b1, 3'(a), dv, lat, wec, rdg, rv, oth);
    end
    apply_reset();
    act0 = 1'b0; act1 = 1'b0; m_last = 1'b1;
    edge_n = 0; next_sample = 1; sched_edge = -10;
    sched_port = 1'b0; sched_we = 1'b0;
    m_addr = '0; m_wd = '0; m_rd = '0; pend_rd = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!act0 && $urandom_range(0, 3) == 0) begin
        act0 = 1'b1;
        set_port(1'b0, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      end
      if (!act1 && $urandom_range(0, 3) == 0) begin
        act1 = 1'b1;
        set_port(1'b1, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      end
      r0 = REQ0; w0 = WE0; a0 = ADDR0; d0 = WD0;
      r1 = REQ1; w1 = WE1; a1 = ADDR1; d1 = WD1;
      tick();
      edge_n++;
      if (edge_n >= next_sample && (r0 || r1)) begin
        p           = tb_pick(r0, r1, m_last);
        sched_edge  = edge_n;
        sched_port  = p;
        sched_we    = p ? w1 : w0;
        m_addr      = p ? a1 : a0;
        m_wd        = p ? d1 : d0;
        next_sample = edge_n + 3;
        m_last      = p;
        if (sched_we) ref_mem[m_addr] = m_wd;
        else          pend_rd = ref_mem[m_addr];
      end
      if (edge_n == sched_edge + 1 && !sched_we) m_rd = pend_rd;
      exp = {(edge_n == sched_edge + 1) && !sched_port,
             (edge_n == sched_edge + 1) && sched_port,
             (edge_n == sched_edge + 1) && !sched_we,
             (edge_n == sched_edge) || (edge_n == sched_edge + 1),
             (edge_n == sched_edge) && sched_we,
             m_addr, m_wd, m_rd};
      got = {GNT0, GNT1, RVALID, BUSY, BANK_WE, BANK_ADDR, BANK_WD, RD};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL random_cyc%0d: got %h expected %h", cyc, got, exp);
      end
      if (GNT0 && act0) begin act0 = 1'b0; REQ0 = 1'b0; end
      if (GNT1 && act1) begin act1 = 1'b0; REQ1 = 1'b0; end
    end
  endtask

  initial begin
    RN = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
    ADDR0 = '0; ADDR1 = '0; WD0 = '0; WD1 = '0;
    test_reset();
    test_write_read();
    test_tie();
    test_simul_writes();
    test_reset_midop();
    test_drop_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
